// File: rtl/tflaf_mse_monitor.sv
// tflaf_mse_monitor: block-averaged mean-square error of the adaptive filter
// error stream. Drops the first RET valid samples of each trial, squares and
// accumulates 2^LOG_BLK samples per block, emits one saturated MSE word per
// block and raises a sticky flag once CONV_BLKS consecutive blocks fall below
// THRESH.
module tflaf_mse_monitor #(
  parameter int               WIDTH     = 16,
  parameter int               QP        = 12,
  parameter int               LOG_BLK   = 8,
  parameter int               RET       = 5,
  parameter logic [WIDTH-1:0] THRESH    = 16'h0010,
  parameter int               CONV_BLKS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] err_in,
  input  logic             err_valid,
  output logic [WIDTH-1:0] mse_out,
  output logic             mse_valid,
  output logic [15:0]      blk_count,
  output logic             converged,
  output logic             busy
);

  localparam int SQ_W    = 2 * WIDTH;
  localparam int ACC_W   = 2 * WIDTH + LOG_BLK;
  localparam int SHIFT   = LOG_BLK + QP;
  localparam int SKIP_W  = (RET > 0) ? $clog2(RET + 1) : 1;
  localparam int BELOW_W = $clog2(CONV_BLKS + 1);

  localparam logic [ACC_W-1:0]   MSE_MAX   = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [SKIP_W-1:0]  SKIP_LOAD = SKIP_W'(RET);
  localparam logic [BELOW_W-1:0] BELOW_SAT = BELOW_W'(CONV_BLKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SKIP,
    S_RUN
  } state_t;

  // With no retiming latency to cover, a trial goes straight to accumulation.
  localparam state_t START_STATE = (RET == 0) ? S_RUN : S_SKIP;

  // Signed x signed square; the result is never negative, so it is kept
  // as an unsigned 2*WIDTH-bit value with 2*QP fractional bits.
  function automatic logic [SQ_W-1:0] square(input logic [WIDTH-1:0] x);
    logic signed [SQ_W-1:0] xs;
    xs = SQ_W'($signed(x));
    return $unsigned(xs * xs);
  endfunction

  // Divide the block sum by 2^LOG_BLK and drop the extra QP fraction bits
  // (floor), then clamp to the largest positive WIDTH-bit word.
  function automatic logic [WIDTH-1:0] sat_mse(input logic [ACC_W-1:0] total);
    logic [ACC_W-1:0] m;
    m = total >> SHIFT;
    if (m > MSE_MAX) begin
      return MSE_MAX[WIDTH-1:0];
    end else begin
      return m[WIDTH-1:0];
    end
  endfunction

  state_t               state_q,  state_d;
  logic [SKIP_W-1:0]    skip_q,   skip_d;
  logic [LOG_BLK-1:0]   cnt_q,    cnt_d;
  logic [SQ_W-1:0]      sq_p1_q,  sq_p1_d;
  logic                 vld_p1_q, vld_p1_d;
  logic                 last_p1_q, last_p1_d;
  logic [ACC_W-1:0]     acc_q,    acc_d;
  logic [WIDTH-1:0]     mse_q,    mse_d;
  logic                 mse_vld_q, mse_vld_d;
  logic [15:0]          blk_q,    blk_d;
  logic [BELOW_W-1:0]   below_q,  below_d;
  logic                 conv_q,   conv_d;
  logic                 busy_q,   busy_d;

  logic [ACC_W-1:0]     blk_sum;
  logic [WIDTH-1:0]     mse_new;
  logic [BELOW_W-1:0]   below_next;
  logic                 take;

  // Next-state: trial FSM, square stage (p1), accumulate/emit stage, convergence.
  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    cnt_d      = cnt_q;
    sq_p1_d    = sq_p1_q;
    vld_p1_d   = 1'b0;
    last_p1_d  = 1'b0;
    acc_d      = acc_q;
    mse_d      = mse_q;
    mse_vld_d  = 1'b0;
    blk_d      = blk_q;
    below_d    = below_q;
    conv_d     = conv_q;
    take       = 1'b0;

    // The last square of a block is still in p1 when the block closes, so
    // the reported sum includes it directly.
    blk_sum    = acc_q + ACC_W'(sq_p1_q);
    mse_new    = sat_mse(blk_sum);
    below_next = (mse_new < THRESH) ?
                 ((below_q == BELOW_SAT) ? below_q : below_q + 1'b1) : '0;

    if (start) begin
      // A new trial wipes block progress; mse_out keeps its last value and
      // any block finishing on this edge is dropped.
      state_d = START_STATE;
      skip_d  = SKIP_LOAD;
      cnt_d   = '0;
      sq_p1_d = '0;
      acc_d   = '0;
      blk_d   = '0;
      below_d = '0;
      conv_d  = 1'b0;
    end else begin
      // Stage 2: fold p1 into the accumulator, or close the block.
      if (vld_p1_q) begin
        if (last_p1_q) begin
          mse_d     = mse_new;
          mse_vld_d = 1'b1;
          acc_d     = '0;
          below_d   = below_next;
          conv_d    = conv_q | (below_next == BELOW_SAT);
          if (blk_q != 16'hFFFF) begin
            blk_d = blk_q + 16'd1;
          end
        end else begin
          acc_d = blk_sum;
        end
      end

      case (state_q)
        S_SKIP: begin
          if (err_valid) begin
            skip_d = skip_q - 1'b1;
            if (skip_q == SKIP_W'(1)) begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN:   take = err_valid;
        default: take = 1'b0;
      endcase

      // Stage 1: square the accepted sample and tag the block's final one.
      if (take) begin
        sq_p1_d   = square(err_in);
        vld_p1_d  = 1'b1;
        last_p1_d = &cnt_q;
        cnt_d     = cnt_q + 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and pipeline registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      skip_q    <= '0;
      cnt_q     <= '0;
      sq_p1_q   <= '0;
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
      acc_q     <= '0;
      mse_q     <= '0;
      mse_vld_q <= 1'b0;
      blk_q     <= '0;
      below_q   <= '0;
      conv_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      cnt_q     <= cnt_d;
      sq_p1_q   <= sq_p1_d;
      vld_p1_q  <= vld_p1_d;
      last_p1_q <= last_p1_d;
      acc_q     <= acc_d;
      mse_q     <= mse_d;
      mse_vld_q <= mse_vld_d;
      blk_q     <= blk_d;
      below_q   <= below_d;
      conv_q    <= conv_d;
      busy_q    <= busy_d;
    end
  end

  assign mse_out   = mse_q;
  assign mse_valid = mse_vld_q;
  assign blk_count = blk_q;
  assign converged = conv_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_tflaf_mse_monitor.sv
// Bench for tflaf_mse_monitor: two instances (RET=0/CONV_BLKS=3 and
// RET=5/CONV_BLKS=4, both LOG_BLK=2) share one input stream and are checked
// every cycle against a transaction-level model, plus directed spot values.
module tb_tflaf_mse_monitor;

  localparam int LB = 2;
  localparam int QP = 12;
  localparam logic [15:0] TH = 16'h0010;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        err_valid = 1'b0;
  logic [15:0] err_in = 16'h0000;

  logic [15:0] o_mse[2];
  logic        o_mv[2];
  logic [15:0] o_bc[2];
  logic        o_cv[2];
  logic        o_bz[2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  tflaf_mse_monitor #(.WIDTH(16), .QP(12), .LOG_BLK(2), .RET(0),
                      .THRESH(16'h0010), .CONV_BLKS(3)) dut_a (
    .clk(clk), .reset(reset), .start(start), .err_in(err_in), .err_valid(err_valid),
    .mse_out(o_mse[0]), .mse_valid(o_mv[0]), .blk_count(o_bc[0]),
    .converged(o_cv[0]), .busy(o_bz[0]));

  tflaf_mse_monitor #(.WIDTH(16), .QP(12), .LOG_BLK(2), .RET(5),
                      .THRESH(16'h0010), .CONV_BLKS(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .err_in(err_in), .err_valid(err_valid),
    .mse_out(o_mse[1]), .mse_valid(o_mv[1]), .blk_count(o_bc[1]),
    .converged(o_cv[1]), .busy(o_bz[1]));

  // Reference model: trial mode, running block sum, and a block result that
  // becomes visible one edge after its last sample unless a start intervenes.
  int          ret[2] = '{0, 5};
  int          cb[2]  = '{3, 4};
  int          m_mode[2];   // 0 idle, 1 skipping, 2 running
  int          m_skip[2];
  int          m_n[2];
  int          m_below[2];
  longint      m_sum[2];
  longint      m_psum[2];
  bit          m_pend[2];
  logic        m_valid[2];
  logic [15:0] m_mse[2];
  logic [15:0] m_blk[2];
  logic        m_conv[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_skip[k] = 0; m_n[k] = 0; m_below[k] = 0;
      m_sum[k] = 0; m_psum[k] = 0; m_pend[k] = 0;
      m_valid[k] = 1'b0; m_mse[k] = 16'h0; m_blk[k] = 16'h0; m_conv[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit s, input bit v, input logic [15:0] d);
    longint q;
    longint e;
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0;
      if (s) begin
        m_mode[k] = (ret[k] == 0) ? 2 : 1;
        m_skip[k] = ret[k];
        m_n[k] = 0; m_sum[k] = 0; m_pend[k] = 0;
        m_blk[k] = 16'h0; m_below[k] = 0; m_conv[k] = 1'b0;
      end else begin
        if (m_pend[k]) begin
          q = m_psum[k] / (longint'(1) << (LB + QP));
          if (q > 32767) q = 32767;
          m_mse[k] = 16'(q);
          m_valid[k] = 1'b1;
          if (m_blk[k] != 16'hFFFF) m_blk[k] = m_blk[k] + 16'd1;
          if (q < longint'(TH)) begin
            if (m_below[k] < cb[k]) m_below[k] = m_below[k] + 1;
          end else begin
            m_below[k] = 0;
          end
          if (m_below[k] >= cb[k]) m_conv[k] = 1'b1;
          m_pend[k] = 0;
        end
        if (v && m_mode[k] == 1) begin
          m_skip[k] = m_skip[k] - 1;
          if (m_skip[k] == 0) m_mode[k] = 2;
        end else if (v && m_mode[k] == 2) begin
          e = longint'($signed(d));
          m_sum[k] = m_sum[k] + e * e;
          m_n[k] = m_n[k] + 1;
          if (m_n[k] == (1 << LB)) begin
            m_pend[k] = 1; m_psum[k] = m_sum[k]; m_sum[k] = 0; m_n[k] = 0;
          end
        end
      end
    end
  endtask

  // Drive one cycle of stimulus, advance the model, settle past the edge.
  task automatic step(input bit s, input bit v, input logic [15:0] d);
    start = s; err_valid = v; err_in = d;
    @(posedge clk);
    model_edge(s, v, d);
    #1;
    start = 1'b0; err_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1; err_valid = 1'b1; err_in = 16'h7FFF;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0; err_valid = 1'b0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({o_mv[k], o_mse[k], o_bc[k], o_cv[k], o_bz[k]} !== 35'h0) begin
        bad++;
        $display("FAIL reset_state dut%0d: got v=%b mse=%h blk=%h conv=%b busy=%b, want all 0",
                 k, o_mv[k], o_mse[k], o_bc[k], o_cv[k], o_bz[k]);
      end
    end
    reset = 1'b1;
    // Samples with no trial running must be ignored.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 16'h7FFF);
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({o_mv[k], o_mse[k], o_bc[k], o_cv[k], o_bz[k]} !==
            {m_valid[k], m_mse[k], m_blk[k], m_conv[k], 1'(m_mode[k] != 0)}) begin
          bad++;
          $display("FAIL idle_ignore dut%0d cyc%0d: got v=%b mse=%h blk=%h conv=%b busy=%b, want v=%b mse=%h blk=%h conv=%b busy=%b",
                   k, i, o_mv[k], o_mse[k], o_bc[k], o_cv[k], o_bz[k],
                   m_valid[k], m_mse[k], m_blk[k], m_conv[k], m_mode[k] != 0);
        end
      end
    end
  endtask

  task automatic test_first_block();
    step(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 7; i++) begin
      if (i < 4) step(1'b0, 1'b1, 16'h1000);
      else       step(1'b0, 1'b0, 16'h0);
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({o_mv[k], o_mse[k], o_bc[k], o_cv[k], o_bz[k]} !==
            {m_valid[k], m_mse[k], m_blk[k], m_conv[k], 1'(m_mode[k] != 0)}) begin
          bad++;
          $display("FAIL first_block dut%0d cyc%0d: got v=%b mse=%h blk=%h conv=%b busy=%b, want v=%b mse=%h blk=%h conv=%b busy=%b",
                   k, i, o_mv[k], o_mse[k], o_bc[k], o_cv[k], o_bz[k],
                   m_valid[k], m_mse[k], m_blk[k], m_conv[k], m_mode[k] != 0);
        end
      end
      if (i == 4) begin
        total++;
        if (!(o_mv[0] === 1'b1 && o_mse[0] === 16'h1000 && o_bc[0] === 16'd1)) begin
          bad++;
          $display("FAIL first_block_result: got v=%b mse=%h blk=%0d, want v=1 mse=1000 blk=1",
                   o_mv[0], o_mse[0], o_bc[0]);
        end
      end
    end
  endtask

  task automatic test_skip();
    int pulses_b;
    pulses_b = 0;
    step(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 11; i++) begin
      if (i < 5)      step(1'b0, 1'b1, 16'h7FFF);
      else if (i < 9) step(1'b0, 1'b1, 16'h1000);
      else            step(1'b0, 1'b0, 16'h0);
      if (o_mv[1] === 1'b1) pulses_b++;
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({o_mv[k], o_mse[k], o_bc[k], o_cv[k], o_bz[k]} !==
            {m_valid[k], m_mse[k], m_blk[k], m_conv[k], 1'(m_mode[k] != 0)}) begin
          bad++;
          $display("FAIL skip dut%0d cyc%0d: got v=%b mse=%h blk=%h conv=%b busy=%b, want v=%b mse=%h blk=%h conv=%b busy=%b",
                   k, i, o_mv[k], o_mse[k], o_bc[k], o_cv[k], o_bz[k],
                   m_valid[k], m_mse[k], m_blk[k], m_conv[k], m_mode[k] != 0);
        end
      end
    end
    total++;
    if (pulses_b != 1 || o_mse[1] !== 16'h1000 || o_bc[1] !== 16'd1) begin
      bad++;
      $display("FAIL skip_result: got pulses=%0d mse=%h blk=%0d, want pulses=1 mse=1000 blk=1",
               pulses_b, o_mse[1], o_bc[1]);
    end
  endtask

  task automatic test_back_to_back();
    int pcyc[$];
    step(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 14; i++) begin
      if (i < 12) step(1'b0, 1'b1, (i % 2 == 0) ? 16'h0800 : 16'hF800);
      else        step(1'b0, 1'b0, 16'h0);
      if (o_mv[0] === 1'b1) pcyc.push_back(i);
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({o_mv[k], o_mse[k], o_bc[k], o_cv[k], o_bz[k]} !==
            {m_valid[k], m_mse[k], m_blk[k], m_conv[k], 1'(m_mode[k] != 0)}) begin
          bad++;
          $display("FAIL back_to_back dut%0d cyc%0d: got v=%b mse=%h blk=%h conv=%b busy=%b, want v=%b mse=%h blk=%h conv=%b busy=%b",
                   k, i, o_mv[k], o_mse[k], o_bc[k], o_cv[k], o_bz[k],
                   m_valid[k], m_mse[k], m_blk[k], m_conv[k], m_mode[k] != 0);
        end
      end
    end
    total++;
    if (pcyc.size() != 3 || pcyc[1] - pcyc[0] != 4 || pcyc[2] - pcyc[1] != 4 ||
        o_mse[0] !== 16'h0400 || o_bc[0] !== 16'd3) begin
      bad++;
      $display("FAIL back_to_back_spacing: got pulses=%0d mse=%h blk=%0d, want 3 pulses 4 apart mse=0400 blk=3",
               pcyc.size(), o_mse[0], o_bc[0]);
    end
  endtask

  task automatic test_saturation_gaps();
    step(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, (i < 8) && (i % 2 == 0), 16'h8000);
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({o_mv[k], o_mse[k], o_bc[k], o_cv[k], o_bz[k]} !==
            {m_valid[k], m_mse[k], m_blk[k], m_conv[k], 1'(m_mode[k] != 0)}) begin
          bad++;
          $display("FAIL saturation dut%0d cyc%0d: got v=%b mse=%h blk=%h conv=%b busy=%b, want v=%b mse=%h blk=%h conv=%b busy=%b",
                   k, i, o_mv[k], o_mse[k], o_bc[k], o_cv[k], o_bz[k],
                   m_valid[k], m_mse[k], m_blk[k], m_conv[k], m_mode[k] != 0);
        end
      end
    end
    total++;
    if (o_mse[0] !== 16'h7FFF || o_bc[0] !== 16'd1) begin
      bad++;
      $display("FAIL saturation_result: got mse=%h blk=%0d, want mse=7fff blk=1", o_mse[0], o_bc[0]);
    end
  endtask

  task automatic test_convergence();
    logic [15:0] blocks[6] = '{16'h0000, 16'h0000, 16'h1000, 16'h0000, 16'h0000, 16'h0000};
    step(1'b1, 1'b0, 16'h0);
    for (int b = 0; b < 7; b++) begin
      for (int i = 0; i < 4; i++) begin
        if (b < 6) step(1'b0, 1'b1, blocks[b]);
        else       step(1'b0, 1'b0, 16'h0);
        for (int k = 0; k < 2; k++) begin
          total++;
          if ({o_mv[k], o_mse[k], o_bc[k], o_cv[k], o_bz[k]} !==
              {m_valid[k], m_mse[k], m_blk[k], m_conv[k], 1'(m_mode[k] != 0)}) begin
            bad++;
            $display("FAIL convergence dut%0d blk%0d cyc%0d: got v=%b mse=%h blk=%h conv=%b busy=%b, want v=%b mse=%h blk=%h conv=%b busy=%b",
                     k, b, i, o_mv[k], o_mse[k], o_bc[k], o_cv[k], o_bz[k],
                     m_valid[k], m_mse[k], m_blk[k], m_conv[k], m_mode[k] != 0);
          end
        end
        // Pulse of block 5 (index 4) keeps converged low; pulse of block 6 raises it.
        if (b == 5 && i == 0) begin
          total++;
          if (o_cv[0] !== 1'b0) begin
            bad++;
            $display("FAIL conv_early: got converged=%b, want 0", o_cv[0]);
          end
        end
        if (b == 6 && i == 0) begin
          total++;
          if (o_cv[0] !== 1'b1 || o_mv[0] !== 1'b1) begin
            bad++;
            $display("FAIL conv_rise: got converged=%b v=%b, want 1 with pulse", o_cv[0], o_mv[0]);
          end
        end
      end
    end
  endtask

  task automatic test_disturb();
    step(1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h1000);
    step(1'b0, 1'b1, 16'h1000);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({o_mv[k], o_mse[k], o_bc[k], o_cv[k], o_bz[k]} !== 35'h0) begin
        bad++;
        $display("FAIL async_reset dut%0d: got v=%b mse=%h blk=%h conv=%b busy=%b, want all 0",
                 k, o_mv[k], o_mse[k], o_bc[k], o_cv[k], o_bz[k]);
      end
    end
    #2;
    reset = 1'b1;
    step(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 10; i++) begin
      if (i == 2)      step(1'b1, 1'b1, 16'h7FFF);
      else if (i < 2)  step(1'b0, 1'b1, 16'h7FFF);
      else if (i < 7)  step(1'b0, 1'b1, 16'h1000);
      else             step(1'b0, 1'b0, 16'h0);
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({o_mv[k], o_mse[k], o_bc[k], o_cv[k], o_bz[k]} !==
            {m_valid[k], m_mse[k], m_blk[k], m_conv[k], 1'(m_mode[k] != 0)}) begin
          bad++;
          $display("FAIL restart dut%0d cyc%0d: got v=%b mse=%h blk=%h conv=%b busy=%b, want v=%b mse=%h blk=%h conv=%b busy=%b",
                   k, i, o_mv[k], o_mse[k], o_bc[k], o_cv[k], o_bz[k],
                   m_valid[k], m_mse[k], m_blk[k], m_conv[k], m_mode[k] != 0);
        end
      end
    end
    total++;
    if (o_mse[0] !== 16'h1000 || o_bc[0] !== 16'd1 || o_cv[0] !== 1'b0) begin
      bad++;
      $display("FAIL restart_result: got mse=%h blk=%0d conv=%b, want mse=1000 blk=1 conv=0",
               o_mse[0], o_bc[0], o_cv[0]);
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    bit s;
    bit v;
    step(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 600; i++) begin
      s = ($urandom_range(63) == 0);
      v = ($urandom_range(3) != 0);
      d = ($urandom_range(3) == 0) ? 16'($urandom) : 16'($urandom_range(6)) - 16'd3;
      step(s, v, d);
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({o_mv[k], o_mse[k], o_bc[k], o_cv[k], o_bz[k]} !==
            {m_valid[k], m_mse[k], m_blk[k], m_conv[k], 1'(m_mode[k] != 0)}) begin
          bad++;
          $display("FAIL random dut%0d cyc%0d: got v=%b mse=%h blk=%h conv=%b busy=%b, want v=%b mse=%h blk=%h conv=%b busy=%b",
                   k, i, o_mv[k], o_mse[k], o_bc[k], o_cv[k], o_bz[k],
                   m_valid[k], m_mse[k], m_blk[k], m_conv[k], m_mode[k] != 0);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_block();
    test_skip();
    test_back_to_back();
    test_saturation_gaps();
    test_convergence();
    test_disturb();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
